// File: rtl/dat_lookup.sv
// Fetch engine for Device Address Table entries: issues one DAT read per request,
// captures the entry after a fixed latency, decodes the I3C HCI fields and flags errors.
module dat_lookup #(
    parameter int DatAw        = 7,
    parameter int DatDepth     = 128,
    parameter int DatRdLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [DatAw-1:0] req_index_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [63:0]      rsp_entry_o,
    output logic [6:0]       rsp_static_addr_o,
    output logic [6:0]       rsp_dynamic_addr_o,
    output logic             rsp_ibi_payload_o,
    output logic             rsp_ibi_reject_o,
    output logic             rsp_crr_reject_o,
    output logic [1:0]       rsp_nack_retry_o,
    output logic             rsp_is_i2c_o,
    output logic             rsp_err_range_o,
    output logic             rsp_err_parity_o,
    output logic             dat_read_valid_o,
    output logic [DatAw-1:0] dat_index_o,
    input  logic [63:0]      dat_rdata_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    state_t           state;
    logic [1:0]       lat_cnt;
    logic [63:0]      entry_q;
    logic             err_range_q;
    logic             rsp_valid_q;
    logic             req_ready_q;
    logic             rd_valid_q;
    logic [DatAw-1:0] rd_index_q;
    logic             in_range;
    logic [63:0]      entry_vis;

    // One extra bit so DatDepth == 2**DatAw still compares correctly
    assign in_range = ({1'b0, req_index_i} < (DatAw + 1)'(DatDepth));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            entry_q     <= '0;
            err_range_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_index_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (in_range) begin
                            rd_valid_q  <= 1'b1;
                            rd_index_q  <= req_index_i;
                            err_range_q <= 1'b0;
                            state       <= READ;
                        end else begin
                            entry_q     <= '0;
                            err_range_q <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                READ: begin
                    rd_valid_q <= 1'b0;
                    lat_cnt    <= 2'(DatRdLatency - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        entry_q     <= dat_rdata_i;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    // Returning to IDLE re-arms req_ready one cycle later, never same-cycle
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        err_range_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        rd_index_q  <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign entry_vis = rsp_valid_q ? entry_q : 64'd0;

    assign req_ready_o        = req_ready_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_entry_o        = entry_vis;
    assign rsp_static_addr_o  = entry_vis[6:0];
    assign rsp_dynamic_addr_o = entry_vis[22:16];
    assign rsp_ibi_payload_o  = entry_vis[12];
    assign rsp_ibi_reject_o   = entry_vis[13];
    assign rsp_crr_reject_o   = entry_vis[14];
    assign rsp_nack_retry_o   = entry_vis[30:29];
    assign rsp_is_i2c_o       = entry_vis[31];
    assign rsp_err_range_o    = rsp_valid_q & err_range_q;
    // Odd parity over the dynamic address; meaningless for I2C devices and range errors
    assign rsp_err_parity_o   = rsp_valid_q & ~err_range_q & ~entry_q[31] &
                                (entry_q[23] != ~^entry_q[22:16]);
    assign dat_read_valid_o   = rd_valid_q;
    assign dat_index_o        = rd_index_q;
    assign busy_o             = (state != IDLE);

endmodule

// File: tb/tb_dat_lookup.sv
// Directed bench for dat_lookup: one instance at default geometry/latency-1, one at
// depth 16 / latency 3, each fed by a small DAT model that returns data only on the right cycle.
module tb_dat_lookup;

    localparam logic [63:0] GARBAGE = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_req_valid = 1'b0, a_req_ready, a_rsp_valid, a_rsp_ready = 1'b0;
    logic [6:0]  a_req_index = '0, a_static, a_dynamic, a_rd_index;
    logic [63:0] a_entry, a_rdata = '0;
    logic        a_ibi_payload, a_ibi_reject, a_crr_reject, a_is_i2c;
    logic        a_err_range, a_err_parity, a_rd_valid, a_busy;
    logic [1:0]  a_nack_retry;

    logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b0;
    logic [6:0]  b_req_index = '0, b_static, b_dynamic, b_rd_index;
    logic [63:0] b_entry, b_rdata = '0;
    logic        b_ibi_payload, b_ibi_reject, b_crr_reject, b_is_i2c;
    logic        b_err_range, b_err_parity, b_rd_valid, b_busy;
    logic [1:0]  b_nack_retry;
    logic        b_s1 = 1'b0, b_s2 = 1'b0;

    logic [63:0] mem_a [0:127];
    logic [63:0] mem_b [0:127];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dat_lookup u_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_index_i(a_req_index),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_entry_o(a_entry),
        .rsp_static_addr_o(a_static), .rsp_dynamic_addr_o(a_dynamic),
        .rsp_ibi_payload_o(a_ibi_payload), .rsp_ibi_reject_o(a_ibi_reject),
        .rsp_crr_reject_o(a_crr_reject), .rsp_nack_retry_o(a_nack_retry),
        .rsp_is_i2c_o(a_is_i2c), .rsp_err_range_o(a_err_range),
        .rsp_err_parity_o(a_err_parity), .dat_read_valid_o(a_rd_valid),
        .dat_index_o(a_rd_index), .dat_rdata_i(a_rdata), .busy_o(a_busy)
    );

    dat_lookup #(.DatAw(7), .DatDepth(16), .DatRdLatency(3)) u_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_index_i(b_req_index),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_entry_o(b_entry),
        .rsp_static_addr_o(b_static), .rsp_dynamic_addr_o(b_dynamic),
        .rsp_ibi_payload_o(b_ibi_payload), .rsp_ibi_reject_o(b_ibi_reject),
        .rsp_crr_reject_o(b_crr_reject), .rsp_nack_retry_o(b_nack_retry),
        .rsp_is_i2c_o(b_is_i2c), .rsp_err_range_o(b_err_range),
        .rsp_err_parity_o(b_err_parity), .dat_read_valid_o(b_rd_valid),
        .dat_index_o(b_rd_index), .dat_rdata_i(b_rdata), .busy_o(b_busy)
    );

    // DAT model, latency 1: data valid only in the cycle after the strobe
    always @(posedge clk) begin
        a_rdata <= a_rd_valid ? mem_a[a_rd_index] : GARBAGE;
    end

    // DAT model, latency 3: data valid only in the third cycle after the strobe
    always @(posedge clk) begin
        b_s1    <= b_rd_valid;
        b_s2    <= b_s1;
        b_rdata <= b_s2 ? mem_b[b_rd_index] : GARBAGE;
    end

    task automatic lookup_a(input logic [6:0] idx);
        @(negedge clk); a_req_valid = 1'b1; a_req_index = idx;
        @(negedge clk); a_req_valid = 1'b0; a_req_index = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_a();
        a_rsp_ready = 1'b1;
        @(negedge clk); a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (a_req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %0b want 1", a_req_ready); else passed++;
        checks++; if (a_rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %0b want 0", a_rsp_valid); else passed++;
        checks++; if (a_rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %0b want 0", a_rd_valid); else passed++;
        checks++; if (a_rd_index !== 7'd0) $display("[TB] FAIL reset_rd_index: got %0h want 0", a_rd_index); else passed++;
        checks++; if (a_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", a_busy); else passed++;
        checks++; if (a_entry !== 64'd0) $display("[TB] FAIL reset_entry: got %0h want 0", a_entry); else passed++;
        checks++; if (a_err_parity !== 1'b0) $display("[TB] FAIL reset_parity: got %0b want 0", a_err_parity); else passed++;
        checks++; if (b_req_ready !== 1'b1) $display("[TB] FAIL reset_b_req_ready: got %0b want 1", b_req_ready); else passed++;
    endtask

    task automatic test_basic_lookup();
        mem_a[3] = 64'h0000_0000_0009_0050;
        @(negedge clk); a_req_valid = 1'b1; a_req_index = 7'd3;
        checks++; if (a_req_ready !== 1'b1) $display("[TB] FAIL basic_req_ready: got %0b want 1", a_req_ready); else passed++;
        @(negedge clk); a_req_valid = 1'b0; a_req_index = '0;
        checks++; if (a_rd_valid !== 1'b1) $display("[TB] FAIL basic_strobe_n1: got %0b want 1", a_rd_valid); else passed++;
        checks++; if (a_rd_index !== 7'd3) $display("[TB] FAIL basic_index_n1: got %0h want 3", a_rd_index); else passed++;
        checks++; if (a_busy !== 1'b1) $display("[TB] FAIL basic_busy: got %0b want 1", a_busy); else passed++;
        checks++; if (a_req_ready !== 1'b0) $display("[TB] FAIL basic_req_ready_busy: got %0b want 0", a_req_ready); else passed++;
        @(negedge clk);
        checks++; if (a_rd_valid !== 1'b0) $display("[TB] FAIL basic_strobe_n2: got %0b want 0", a_rd_valid); else passed++;
        checks++; if (a_rd_index !== 7'd3) $display("[TB] FAIL basic_index_n2: got %0h want 3", a_rd_index); else passed++;
        checks++; if (a_rsp_valid !== 1'b0) $display("[TB] FAIL basic_rsp_early: got %0b want 0", a_rsp_valid); else passed++;
        @(negedge clk);
        checks++; if (a_rsp_valid !== 1'b1) $display("[TB] FAIL basic_rsp_valid_n3: got %0b want 1", a_rsp_valid); else passed++;
        checks++; if (a_static !== 7'h50) $display("[TB] FAIL basic_static: got %0h want 50", a_static); else passed++;
        checks++; if (a_dynamic !== 7'h09) $display("[TB] FAIL basic_dynamic: got %0h want 09", a_dynamic); else passed++;
        checks++; if (a_err_parity !== 1'b1) $display("[TB] FAIL basic_parity: got %0b want 1", a_err_parity); else passed++;
        checks++; if (a_err_range !== 1'b0) $display("[TB] FAIL basic_range: got %0b want 0", a_err_range); else passed++;
        checks++; if (a_entry !== 64'h0000_0000_0009_0050) $display("[TB] FAIL basic_entry: got %0h want 90050", a_entry); else passed++;
        release_a();
        checks++; if (a_rsp_valid !== 1'b0) $display("[TB] FAIL basic_rsp_drop: got %0b want 0", a_rsp_valid); else passed++;
        checks++; if (a_req_ready !== 1'b1) $display("[TB] FAIL basic_req_ready_back: got %0b want 1", a_req_ready); else passed++;
        checks++; if (a_static !== 7'h00) $display("[TB] FAIL basic_static_idle: got %0h want 0", a_static); else passed++;
        checks++; if (a_rd_index !== 7'd0) $display("[TB] FAIL basic_index_idle: got %0h want 0", a_rd_index); else passed++;
    endtask

    task automatic test_i2c();
        mem_a[5] = 64'h0000_0000_8008_0000;
        lookup_a(7'd5);
        checks++; if (a_rsp_valid !== 1'b1) $display("[TB] FAIL i2c_rsp_valid: got %0b want 1", a_rsp_valid); else passed++;
        checks++; if (a_is_i2c !== 1'b1) $display("[TB] FAIL i2c_flag: got %0b want 1", a_is_i2c); else passed++;
        checks++; if (a_err_parity !== 1'b0) $display("[TB] FAIL i2c_parity: got %0b want 0", a_err_parity); else passed++;
        checks++; if (a_dynamic !== 7'h08) $display("[TB] FAIL i2c_dynamic: got %0h want 08", a_dynamic); else passed++;
        release_a();
        mem_a[5] = 64'h0000_0000_0008_0000;
        lookup_a(7'd5);
        checks++; if (a_is_i2c !== 1'b0) $display("[TB] FAIL i3c_flag: got %0b want 0", a_is_i2c); else passed++;
        checks++; if (a_err_parity !== 1'b0) $display("[TB] FAIL i3c_parity_ok: got %0b want 0", a_err_parity); else passed++;
        checks++; if (a_entry !== 64'h0000_0000_0008_0000) $display("[TB] FAIL i3c_entry: got %0h want 80000", a_entry); else passed++;
        release_a();
    endtask

    task automatic test_range();
        @(negedge clk); b_req_valid = 1'b1; b_req_index = 7'd20;
        @(negedge clk); b_req_valid = 1'b0; b_req_index = '0;
        checks++; if (b_rsp_valid !== 1'b1) $display("[TB] FAIL range_rsp_valid_n1: got %0b want 1", b_rsp_valid); else passed++;
        checks++; if (b_err_range !== 1'b1) $display("[TB] FAIL range_flag: got %0b want 1", b_err_range); else passed++;
        checks++; if (b_entry !== 64'd0) $display("[TB] FAIL range_entry: got %0h want 0", b_entry); else passed++;
        checks++; if (b_rd_valid !== 1'b0) $display("[TB] FAIL range_no_strobe: got %0b want 0", b_rd_valid); else passed++;
        checks++; if (b_err_parity !== 1'b0) $display("[TB] FAIL range_parity: got %0b want 0", b_err_parity); else passed++;
        b_rsp_ready = 1'b1;
        @(negedge clk); b_rsp_ready = 1'b0;
        checks++; if (b_rsp_valid !== 1'b0) $display("[TB] FAIL range_rsp_drop: got %0b want 0", b_rsp_valid); else passed++;
        checks++; if (b_err_range !== 1'b0) $display("[TB] FAIL range_flag_clear: got %0b want 0", b_err_range); else passed++;
        checks++; if (b_req_ready !== 1'b1) $display("[TB] FAIL range_req_ready: got %0b want 1", b_req_ready); else passed++;
    endtask

    task automatic test_latency3();
        mem_b[7] = 64'hDEAD_BEEF_6000_7000;
        @(negedge clk); b_req_valid = 1'b1; b_req_index = 7'd7;
        @(negedge clk); b_req_valid = 1'b0; b_req_index = '0;
        checks++; if (b_rd_valid !== 1'b1) $display("[TB] FAIL lat3_strobe: got %0b want 1", b_rd_valid); else passed++;
        checks++; if (b_rd_index !== 7'd7) $display("[TB] FAIL lat3_index: got %0h want 7", b_rd_index); else passed++;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (b_rsp_valid !== 1'b0) $display("[TB] FAIL lat3_rsp_early_n%0d: got %0b want 0", i, b_rsp_valid); else passed++;
        end
        @(negedge clk);
        checks++; if (b_rsp_valid !== 1'b1) $display("[TB] FAIL lat3_rsp_valid_n5: got %0b want 1", b_rsp_valid); else passed++;
        checks++; if (b_nack_retry !== 2'd3) $display("[TB] FAIL lat3_nack_retry: got %0d want 3", b_nack_retry); else passed++;
        checks++; if (b_ibi_payload !== 1'b1) $display("[TB] FAIL lat3_ibi_payload: got %0b want 1", b_ibi_payload); else passed++;
        checks++; if (b_ibi_reject !== 1'b1) $display("[TB] FAIL lat3_ibi_reject: got %0b want 1", b_ibi_reject); else passed++;
        checks++; if (b_crr_reject !== 1'b1) $display("[TB] FAIL lat3_crr_reject: got %0b want 1", b_crr_reject); else passed++;
        checks++; if (b_is_i2c !== 1'b0) $display("[TB] FAIL lat3_i2c: got %0b want 0", b_is_i2c); else passed++;
        checks++; if (b_err_parity !== 1'b1) $display("[TB] FAIL lat3_parity: got %0b want 1", b_err_parity); else passed++;
        checks++; if (b_entry !== 64'hDEAD_BEEF_6000_7000) $display("[TB] FAIL lat3_entry: got %0h want deadbeef60007000", b_entry); else passed++;
        @(negedge clk);
        checks++; if (b_entry !== 64'hDEAD_BEEF_6000_7000) $display("[TB] FAIL lat3_entry_after_corrupt: got %0h want deadbeef60007000", b_entry); else passed++;
        b_rsp_ready = 1'b1;
        @(negedge clk); b_rsp_ready = 1'b0;
        checks++; if (b_rsp_valid !== 1'b0) $display("[TB] FAIL lat3_rsp_drop: got %0b want 0", b_rsp_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        lookup_a(7'd3);
        a_req_valid = 1'b1; a_req_index = 7'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (a_rsp_valid !== 1'b1) $display("[TB] FAIL bp_rsp_valid_c%0d: got %0b want 1", i, a_rsp_valid); else passed++;
            checks++; if (a_entry !== 64'h0000_0000_0009_0050) $display("[TB] FAIL bp_entry_c%0d: got %0h want 90050", i, a_entry); else passed++;
            checks++; if (a_req_ready !== 1'b0) $display("[TB] FAIL bp_req_ready_c%0d: got %0b want 0", i, a_req_ready); else passed++;
            checks++; if (a_rd_valid !== 1'b0) $display("[TB] FAIL bp_strobe_c%0d: got %0b want 0", i, a_rd_valid); else passed++;
        end
        a_rsp_ready = 1'b1;
        @(negedge clk); a_rsp_ready = 1'b0;
        checks++; if (a_req_ready !== 1'b1) $display("[TB] FAIL bp_bubble_ready: got %0b want 1", a_req_ready); else passed++;
        checks++; if (a_rd_valid !== 1'b0) $display("[TB] FAIL bp_bubble_strobe: got %0b want 0", a_rd_valid); else passed++;
        checks++; if (a_busy !== 1'b0) $display("[TB] FAIL bp_bubble_busy: got %0b want 0", a_busy); else passed++;
        @(negedge clk); a_req_valid = 1'b0; a_req_index = '0;
        checks++; if (a_rd_valid !== 1'b1) $display("[TB] FAIL bp_second_strobe: got %0b want 1", a_rd_valid); else passed++;
        checks++; if (a_rd_index !== 7'd5) $display("[TB] FAIL bp_second_index: got %0h want 5", a_rd_index); else passed++;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_rsp_valid !== 1'b1) $display("[TB] FAIL bp_second_rsp_valid: got %0b want 1", a_rsp_valid); else passed++;
        checks++; if (a_entry !== 64'h0000_0000_0008_0000) $display("[TB] FAIL bp_second_entry: got %0h want 80000", a_entry); else passed++;
        release_a();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); b_req_valid = 1'b1; b_req_index = 7'd7;
        @(negedge clk); b_req_valid = 1'b0; b_req_index = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (b_busy !== 1'b0) $display("[TB] FAIL rstmid_async_busy: got %0b want 0", b_busy); else passed++;
        @(negedge clk); rst = 1'b0;
        checks++; if (b_rsp_valid !== 1'b0) $display("[TB] FAIL rstmid_rsp_valid: got %0b want 0", b_rsp_valid); else passed++;
        checks++; if (b_req_ready !== 1'b1) $display("[TB] FAIL rstmid_req_ready: got %0b want 1", b_req_ready); else passed++;
        checks++; if (b_rd_valid !== 1'b0) $display("[TB] FAIL rstmid_strobe: got %0b want 0", b_rd_valid); else passed++;
        checks++; if (b_rd_index !== 7'd0) $display("[TB] FAIL rstmid_index: got %0h want 0", b_rd_index); else passed++;
        checks++; if (b_entry !== 64'd0) $display("[TB] FAIL rstmid_entry: got %0h want 0", b_entry); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (b_rsp_valid !== 1'b0) $display("[TB] FAIL rstmid_spurious_c%0d: got %0b want 0", i, b_rsp_valid); else passed++;
            checks++; if (b_busy !== 1'b0) $display("[TB] FAIL rstmid_busy_c%0d: got %0b want 0", i, b_busy); else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 64'd0;
            mem_b[i] = 64'd0;
        end
        $display("[TB] starting dat_lookup bench");
        test_reset();
        test_basic_lookup();
        test_i2c();
        test_range();
        test_latency3();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
